// File: rtl/svunit_hw_pkg.sv
// Shared types for the SVUnit hardware result aggregator.
package svunit_hw_pkg;

  localparam int unsigned CH_W_MIN = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    REPORT,
    DONE
  } agg_state_e;

  // Index width for a channel count; a single channel still gets one bit.
  function automatic int unsigned ch_w_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : CH_W_MIN;
  endfunction

endpackage

// File: rtl/svunit_chk_counter.sv
// One channel's saturating pass/fail counter pair.
module svunit_chk_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             valid,
  input  logic             pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             sat_hit
);

  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic             w_inc_pass;
  logic             w_inc_fail;
  logic             w_pass_full;
  logic             w_fail_full;

  assign w_inc_pass  = en & valid & pass;
  assign w_inc_fail  = en & valid & ~pass;
  assign w_pass_full = &r_pass;
  assign w_fail_full = &r_fail;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_pass <= '0;
      r_fail <= '0;
    end else begin
      if (w_inc_pass && !w_pass_full) r_pass <= r_pass + 1'b1;
      if (w_inc_fail && !w_fail_full) r_fail <= r_fail + 1'b1;
    end
  end

  assign pass_cnt = r_pass;
  assign fail_cnt = r_fail;
  assign sat_hit  = (w_inc_pass & w_pass_full) | (w_inc_fail & w_fail_full);

endmodule

// File: rtl/svunit_result_agg.sv
// Multi-channel check aggregator: counts per-channel pass/fail events during a
// run, streams one record per channel on a valid/ready port, then holds a verdict.
module svunit_result_agg
  import svunit_hw_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned CH_W   = ch_w_of(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [NUM_CH-1:0] chk_valid,
  input  logic [NUM_CH-1:0] chk_pass,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [CH_W-1:0]   rpt_ch,
  output logic [CNT_W-1:0]  rpt_pass_cnt,
  output logic [CNT_W-1:0]  rpt_fail_cnt,
  output logic              busy,
  output logic              done,
  output logic              passed,
  output logic              sat,
  output logic              late_chk
);

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
  } rpt_rec_t;

  agg_state_e r_state;
  agg_state_e w_next;

  logic                         r_busy;
  logic                         r_done;
  logic                         r_passed;
  logic                         r_sat;
  logic                         r_late;
  logic                         r_rpt_valid;
  logic [CH_W-1:0]              r_rpt_ch;
  logic [NUM_CH-1:0][CNT_W-1:0] w_pass_cnt;
  logic [NUM_CH-1:0][CNT_W-1:0] w_fail_cnt;
  logic [NUM_CH-1:0]            w_sat_hit;
  logic                         w_in_run;
  logic                         w_start_acc;
  logic                         w_hs;
  logic                         w_last;
  logic                         w_verdict;
  rpt_rec_t                     w_rec;

  assign w_in_run    = (r_state == RUN);
  assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_hs        = r_rpt_valid & rpt_ready;
  assign w_last      = (r_rpt_ch == CH_W'(NUM_CH - 1));
  assign w_verdict   = !(|w_fail_cnt) && (|w_pass_cnt);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    svunit_chk_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (w_start_acc),
      .en      (w_in_run),
      .valid   (chk_valid[g]),
      .pass    (chk_pass[g]),
      .pass_cnt(w_pass_cnt[g]),
      .fail_cnt(w_fail_cnt[g]),
      .sat_hit (w_sat_hit[g])
    );
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (stop) w_next = REPORT;
      REPORT:  if (w_hs && w_last) w_next = DONE;
      DONE:    if (start) w_next = RUN;
      default: w_next = IDLE;
    endcase
  end

  // Counters are frozen outside RUN, so the record is a live mux of them.
  always_comb begin
    w_rec = '0;
    if (r_rpt_valid) begin
      w_rec.ch       = r_rpt_ch;
      w_rec.pass_cnt = w_pass_cnt[r_rpt_ch];
      w_rec.fail_cnt = w_fail_cnt[r_rpt_ch];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_passed    <= 1'b0;
      r_sat       <= 1'b0;
      r_late      <= 1'b0;
      r_rpt_valid <= 1'b0;
      r_rpt_ch    <= '0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next == RUN) || (w_next == REPORT);
      r_done      <= (w_next == DONE);
      r_rpt_valid <= (w_next == REPORT);
      if (r_state != REPORT) r_rpt_ch <= '0;
      else if (w_hs)         r_rpt_ch <= r_rpt_ch + 1'b1;
      // Run entry clears the sticky flags even if stray events arrive with start.
      if (w_start_acc) begin
        r_passed <= 1'b0;
        r_sat    <= 1'b0;
        r_late   <= 1'b0;
      end else begin
        if ((r_state == REPORT) && (w_next == DONE)) r_passed <= w_verdict;
        if (|w_sat_hit) r_sat <= 1'b1;
        if (!w_in_run && (|chk_valid)) r_late <= 1'b1;
      end
    end
  end

  assign rpt_valid    = r_rpt_valid;
  assign rpt_ch       = w_rec.ch;
  assign rpt_pass_cnt = w_rec.pass_cnt;
  assign rpt_fail_cnt = w_rec.fail_cnt;
  assign busy         = r_busy;
  assign done         = r_done;
  assign passed       = r_passed;
  assign sat          = r_sat;
  assign late_chk     = r_late;

endmodule

// File: tb/tb_svunit_result_agg.sv
// Self-checking bench for svunit_result_agg: directed scenarios plus random traffic
// against a behavioural model of the run/report/verdict rules.
module tb_svunit_result_agg;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned MAXC = (1 << CW) - 1;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_REP  = 2;
  localparam int PH_DONE = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           stop;
  logic [NCH-1:0] chk_valid;
  logic [NCH-1:0] chk_pass;
  logic           rpt_ready;
  logic           rpt_valid;
  logic [1:0]     rpt_ch;
  logic [CW-1:0]  rpt_pass_cnt;
  logic [CW-1:0]  rpt_fail_cnt;
  logic           busy;
  logic           done;
  logic           passed;
  logic           sat;
  logic           late_chk;

  svunit_result_agg #(
    .NUM_CH(NCH),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .chk_valid   (chk_valid),
    .chk_pass    (chk_pass),
    .rpt_valid   (rpt_valid),
    .rpt_ready   (rpt_ready),
    .rpt_ch      (rpt_ch),
    .rpt_pass_cnt(rpt_pass_cnt),
    .rpt_fail_cnt(rpt_fail_cnt),
    .busy        (busy),
    .done        (done),
    .passed      (passed),
    .sat         (sat),
    .late_chk    (late_chk)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_ok  = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  typedef struct {
    int ch;
    int p;
    int f;
    int cyc;
  } rec_t;
  rec_t recs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_ok++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural model: phase, per-channel tallies and sticky flags.
  int          ph;
  int unsigned mp[NCH];
  int unsigned mf[NCH];
  bit          m_sat, m_late, m_passed;
  int          m_idx;
  bit          m_any_fail, m_any_pass;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      ph = PH_IDLE; m_sat = 0; m_late = 0; m_passed = 0; m_idx = 0;
      for (int i = 0; i < NCH; i++) begin mp[i] = 0; mf[i] = 0; end
    end else begin
      if (ph != PH_RUN && chk_valid != '0) m_late = 1;
      if (ph == PH_RUN) begin
        for (int i = 0; i < NCH; i++) begin
          if (chk_valid[i]) begin
            if (chk_pass[i]) begin
              if (mp[i] == MAXC) m_sat = 1; else mp[i]++;
            end else begin
              if (mf[i] == MAXC) m_sat = 1; else mf[i]++;
            end
          end
        end
      end
      case (ph)
        PH_IDLE, PH_DONE: if (start) begin
          for (int i = 0; i < NCH; i++) begin mp[i] = 0; mf[i] = 0; end
          m_sat = 0; m_late = 0; m_passed = 0; ph = PH_RUN;
        end
        PH_RUN: if (stop) begin ph = PH_REP; m_idx = 0; end
        PH_REP: if (rpt_ready) begin
          if (m_idx == NCH - 1) begin
            m_any_fail = 0; m_any_pass = 0;
            for (int i = 0; i < NCH; i++) begin
              if (mf[i] != 0) m_any_fail = 1;
              if (mp[i] != 0) m_any_pass = 1;
            end
            m_passed = !m_any_fail && m_any_pass;
            ph = PH_DONE;
          end else m_idx++;
        end
        default: ph = PH_IDLE;
      endcase
    end
  end

  bit          e_valid;
  int unsigned e_pc, e_fc;

  always @(negedge clk) begin
    if (cmp_en) begin
      e_valid = (ph == PH_REP);
      e_pc = e_valid ? mp[m_idx] : 0;
      e_fc = e_valid ? mf[m_idx] : 0;
      chk("rpt_valid", rpt_valid, e_valid);
      if (e_valid) chk("rpt_ch", rpt_ch, m_idx);
      chk("rpt_pass_cnt", rpt_pass_cnt, e_pc);
      chk("rpt_fail_cnt", rpt_fail_cnt, e_fc);
      chk("busy", busy, (ph == PH_RUN) || (ph == PH_REP));
      chk("done", done, ph == PH_DONE);
      chk("passed", passed, m_passed);
      chk("sat", sat, m_sat);
      chk("late_chk", late_chk, m_late);
    end
    if (rpt_valid === 1'b1 && rpt_ready === 1'b1)
      recs.push_back('{int'(rpt_ch), int'(rpt_pass_cnt), int'(rpt_fail_cnt), cyc});
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic step(input logic s, input logic p, input logic [NCH-1:0] v, input logic [NCH-1:0] ps);
    start = s; stop = p; chk_valid = v; chk_pass = ps;
    @(posedge clk); #1;
  endtask

  task automatic drain(input bit bp, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 60 && dcyc < 0; i++) begin
      rpt_ready = bp ? (i % 3 == 2) : 1'b1;
      step(0, 0, '0, '0);
      if (done) dcyc = cyc;
    end
    chk("drain_timeout", dcyc >= 0, 1);
  endtask

  task automatic check_recs(input string tag, input int ep[NCH], input int ef[NCH]);
    chk({tag, "_nrec"}, recs.size(), NCH);
    for (int i = 0; i < NCH && i < recs.size(); i++) begin
      chk({tag, "_rec_ch"}, recs[i].ch, i);
      chk({tag, "_rec_pass"}, recs[i].p, ep[i]);
      chk({tag, "_rec_fail"}, recs[i].f, ef[i]);
    end
  endtask

  int d;
  int ep[NCH];
  int ef[NCH];

  initial begin
    rst = 1; start = 0; stop = 0; chk_valid = '0; chk_pass = '0; rpt_ready = 0;
    @(posedge clk); #1;
    step(0, 0, '0, '0);
    cmp_en = 1;
    chk("rst_rpt_valid", rpt_valid, 0);
    chk("rst_rpt_ch", rpt_ch, 0);
    chk("rst_pass_cnt", rpt_pass_cnt, 0);
    chk("rst_fail_cnt", rpt_fail_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_passed", passed, 0);
    chk("rst_sat", sat, 0);
    chk("rst_late", late_chk, 0);
    rst = 0;

    // Scenario 1: passes on ch0/ch2, streaming with ready held high.
    step(1, 0, '0, '0);
    step(0, 0, 4'b0101, 4'b0101);
    step(0, 0, 4'b0001, 4'b0001);
    step(0, 0, 4'b0001, 4'b0001);
    recs.delete(); rpt_ready = 1;
    step(0, 1, '0, '0);
    chk("s1_valid_after_stop", rpt_valid, 1);
    drain(0, d);
    ep = '{3, 0, 1, 0}; ef = '{0, 0, 0, 0};
    check_recs("s1", ep, ef);
    chk("s1_passed", passed, 1);

    // Scenario 2: ch1 fail lands in the stop cycle.
    step(1, 0, '0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 4'b0001, 4'b0001);
    recs.delete();
    step(0, 1, 4'b0011, 4'b0001);
    drain(0, d);
    ep = '{5, 0, 0, 0}; ef = '{0, 1, 0, 0};
    check_recs("s2", ep, ef);
    chk("s2_passed", passed, 0);

    // Scenario 3: back-pressure 0,0,1.
    step(1, 0, '0, '0);
    step(0, 0, 4'b1010, 4'b1010);
    step(0, 0, 4'b1010, 4'b1010);
    recs.delete(); rpt_ready = 0;
    step(0, 1, '0, '0);
    drain(1, d);
    ep = '{0, 2, 0, 2}; ef = '{0, 0, 0, 0};
    check_recs("s3", ep, ef);
    if (recs.size() == NCH) begin
      chk("s3_done_after_last", d, recs[NCH-1].cyc + 1);
      for (int i = 0; i + 1 < NCH; i++) chk("s3_stall_gap", recs[i+1].cyc - recs[i].cyc, 3);
    end
    chk("s3_passed", passed, 1);

    // Scenario 4: saturation on ch3.
    step(1, 0, '0, '0);
    for (int i = 0; i < 20; i++) step(0, 0, 4'b1000, 4'b1000);
    recs.delete();
    step(0, 1, '0, '0);
    drain(0, d);
    ep = '{0, 0, 0, 15}; ef = '{0, 0, 0, 0};
    check_recs("s4", ep, ef);
    chk("s4_sat", sat, 1);
    chk("s4_passed", passed, 1);
    step(1, 0, '0, '0);
    chk("s4_sat_cleared", sat, 0);
    chk("s4_busy", busy, 1);
    step(0, 1, '0, '0);
    drain(0, d);
    chk("s4_empty_passed", passed, 0);

    // Scenario 5: stray event in IDLE.
    rst = 1; step(0, 0, '0, '0); rst = 0;
    step(0, 0, 4'b0001, 4'b0000);
    chk("s5_late_set", late_chk, 1);
    step(1, 0, '0, '0);
    chk("s5_late_cleared", late_chk, 0);
    step(0, 1, '0, '0);
    drain(0, d);
    chk("s5_passed", passed, 0);

    // Scenario 6: reset while reporting channel 2, then start+stop together.
    step(1, 0, '0, '0);
    step(0, 0, 4'b0111, 4'b0111);
    rpt_ready = 1;
    step(0, 1, '0, '0);
    for (int i = 0; i < 10 && rpt_ch != 2; i++) step(0, 0, '0, '0);
    chk("s6_at_ch2", rpt_ch, 2);
    rst = 1; rpt_ready = 0;
    step(0, 0, '0, '0);
    rst = 0;
    chk("s6_rst_valid", rpt_valid, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_pass_cnt", rpt_pass_cnt, 0);
    step(1, 1, '0, '0);
    chk("s6_run_busy", busy, 1);
    chk("s6_run_valid", rpt_valid, 0);
    step(0, 0, '0, '0);
    chk("s6_still_run", rpt_valid, 0);
    step(0, 1, '0, '0);
    drain(0, d);

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      logic s, p;
      logic [NCH-1:0] v, ps;
      rst = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 15) == 0);
      p = ($urandom_range(0, 11) == 0);
      v = NCH'($urandom);
      ps = NCH'($urandom);
      if (s) v = '0;
      rpt_ready = ($urandom_range(0, 2) != 0);
      step(s, p, v, ps);
    end

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
